// File: rtl/mvau_fold_ctrl_pkg.sv
// Shared defaults and types for the MVAU fold controller.
package mvau_defn;

    localparam int unsigned SF_DEF     = 32'd4;
    localparam int unsigned NF_DEF     = 32'd3;
    localparam int unsigned DP_LAT_DEF = 32'd2;

    typedef enum logic [0:0] {
        LOAD   = 1'b0,
        REPLAY = 1'b1
    } fold_state_e;

    // Address width that never collapses to zero bits for a single-entry space.
    function automatic int unsigned addr_bw(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/mvau_fold_cnt.sv
// Mod-N up counter with enable and a combinational terminal-count flag.
module mvau_fold_cnt #(
    parameter int unsigned N = 32'd4,
    parameter int unsigned W = 32'd2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wrap_s;

    assign wrap_s = (cnt_q == W'(N - 32'd1));
    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_s;

    // Next count: advance on enable, return to zero after the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (wrap_s) begin
                cnt_d = {W{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mvau_fold_ctrl.sv
// Fold sequencer: loads SF beats of an input vector, replays them NF-1 more
// times, and drives weight addresses, MAC strobes and the output-valid stream.
module mvau_fold_ctrl
    import mvau_defn::*;
#(
    parameter int unsigned SF           = SF_DEF,
    parameter int unsigned NF           = NF_DEF,
    parameter int unsigned DP_LAT       = DP_LAT_DEF,
    parameter int unsigned WMEM_ADDR_BW = addr_bw(SF * NF),
    parameter int unsigned IBUF_ADDR_BW = addr_bw(SF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_v,
    output logic                    in_rdy,
    output logic                    ibuf_we,
    output logic [IBUF_ADDR_BW-1:0] ibuf_waddr,
    output logic [IBUF_ADDR_BW-1:0] ibuf_raddr,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    sel_buf,
    output logic                    mac_en,
    output logic                    acc_clr,
    output logic                    acc_last,
    output logic                    out_v,
    input  logic                    out_rdy
);

    localparam int unsigned NF_BW = addr_bw(NF);

    fold_state_e state_q, state_d;
    logic        rdy_en_q;
    logic        mac_en_q, mac_en_d;
    logic        acc_clr_q, acc_clr_d;
    logic        acc_last_q, acc_last_d;
    logic        sel_buf_q, sel_buf_d;
    logic [DP_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [DP_LAT:0]   vld_ext_s;

    logic                    stall_s;
    logic                    in_rdy_s;
    logic                    issue_s;
    logic [IBUF_ADDR_BW-1:0] sf_cnt_s;
    logic [NF_BW-1:0]        nf_cnt_s;
    logic [WMEM_ADDR_BW-1:0] wm_cnt_s;
    logic                    sf_wrap_s, nf_wrap_s, wm_wrap_s;
    logic                    unused_s;

    assign stall_s = vld_sr_q[DP_LAT-1] & ~out_rdy;

    mvau_fold_cnt #(.N(SF), .W(IBUF_ADDR_BW)) u_sf_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (issue_s),
        .cnt_o  (sf_cnt_s),
        .wrap_o (sf_wrap_s)
    );

    mvau_fold_cnt #(.N(NF), .W(NF_BW)) u_nf_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (issue_s & sf_wrap_s),
        .cnt_o  (nf_cnt_s),
        .wrap_o (nf_wrap_s)
    );

    mvau_fold_cnt #(.N(SF * NF), .W(WMEM_ADDR_BW)) u_wm_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (issue_s),
        .cnt_o  (wm_cnt_s),
        .wrap_o (wm_wrap_s)
    );

    // State decode: who may issue a beat this cycle and where the FSM goes next.
    always_comb begin
        state_d  = state_q;
        in_rdy_s = 1'b0;
        issue_s  = 1'b0;
        case (state_q)
            LOAD: begin
                in_rdy_s = rdy_en_q & ~stall_s;
                issue_s  = in_v & in_rdy_s;
                if (issue_s & sf_wrap_s & ~nf_wrap_s) begin
                    state_d = REPLAY;
                end else begin
                    state_d = LOAD;
                end
            end
            REPLAY: begin
                issue_s = ~stall_s;
                if (issue_s & sf_wrap_s & nf_wrap_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = REPLAY;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Issue strobes and valid pipeline; everything freezes while the output is stalled.
    always_comb begin
        mac_en_d   = mac_en_q;
        acc_clr_d  = acc_clr_q;
        acc_last_d = acc_last_q;
        sel_buf_d  = sel_buf_q;
        vld_ext_s  = {vld_sr_q, mac_en_q & acc_last_q};
        vld_sr_d   = vld_sr_q;
        if (!stall_s) begin
            mac_en_d   = issue_s;
            acc_clr_d  = issue_s & (sf_cnt_s == {IBUF_ADDR_BW{1'b0}});
            acc_last_d = issue_s & sf_wrap_s;
            sel_buf_d  = (state_q == REPLAY);
            vld_sr_d   = vld_ext_s[DP_LAT-1:0];
        end else begin
            vld_sr_d   = vld_sr_q;
        end
    end

    // State and strobe registers; in_rdy stays low until the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            rdy_en_q   <= 1'b0;
            mac_en_q   <= 1'b0;
            acc_clr_q  <= 1'b0;
            acc_last_q <= 1'b0;
            sel_buf_q  <= 1'b0;
            vld_sr_q   <= {DP_LAT{1'b0}};
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= 1'b1;
            mac_en_q   <= mac_en_d;
            acc_clr_q  <= acc_clr_d;
            acc_last_q <= acc_last_d;
            sel_buf_q  <= sel_buf_d;
            vld_sr_q   <= vld_sr_d;
        end
    end

    assign in_rdy     = in_rdy_s;
    assign ibuf_we    = (state_q == LOAD) & issue_s;
    assign ibuf_waddr = sf_cnt_s;
    assign ibuf_raddr = sf_cnt_s;
    assign wmem_addr  = wm_cnt_s;
    assign sel_buf    = sel_buf_q;
    assign mac_en     = mac_en_q;
    assign acc_clr    = acc_clr_q;
    assign acc_last   = acc_last_q;
    assign out_v      = vld_sr_q[DP_LAT-1];

    assign unused_s = ^{nf_cnt_s, wm_wrap_s};

endmodule

// File: tb/tb_mvau_fold_ctrl.sv
// Directed bench for mvau_fold_ctrl: SF=4/NF=3/DP_LAT=2 instance plus an SF=1/NF=1 instance.
module tb_mvau_fold_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_v, out_rdy, in_v1, out_rdy1;
    logic       in_rdy, ibuf_we, sel_buf, mac_en, acc_clr, acc_last, out_v;
    logic [1:0] ibuf_waddr, ibuf_raddr;
    logic [3:0] wmem_addr;
    logic       in_rdy1, ibuf_we1, sel_buf1, mac_en1, acc_clr1, acc_last1, out_v1;
    logic [0:0] ibuf_waddr1, ibuf_raddr1, wmem_addr1;

    int n_checks = 0;
    int n_fails  = 0;
    int pulses, b, pb;
    logic prev_issue, issue_m, lo;

    always #5 clk = ~clk;

    mvau_fold_ctrl #(.SF(4), .NF(3), .DP_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(in_rdy), .ibuf_we(ibuf_we),
        .ibuf_waddr(ibuf_waddr), .ibuf_raddr(ibuf_raddr), .wmem_addr(wmem_addr),
        .sel_buf(sel_buf), .mac_en(mac_en), .acc_clr(acc_clr), .acc_last(acc_last),
        .out_v(out_v), .out_rdy(out_rdy)
    );

    mvau_fold_ctrl #(.SF(1), .NF(1), .DP_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_v(in_v1), .in_rdy(in_rdy1), .ibuf_we(ibuf_we1),
        .ibuf_waddr(ibuf_waddr1), .ibuf_raddr(ibuf_raddr1), .wmem_addr(wmem_addr1),
        .sel_buf(sel_buf1), .mac_en(mac_en1), .acc_clr(acc_clr1), .acc_last(acc_last1),
        .out_v(out_v1), .out_rdy(out_rdy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_v     = 1'b0;
        in_v1    = 1'b0;
        out_rdy  = 1'b1;
        out_rdy1 = 1'b1;
        #1;
        chk("rst_in_rdy",   32'(in_rdy),    32'(0));
        chk("rst_ibuf_we",  32'(ibuf_we),   32'(0));
        chk("rst_wmem",     32'(wmem_addr), 32'(0));
        chk("rst_mac_en",   32'(mac_en),    32'(0));
        chk("rst_acc_clr",  32'(acc_clr),   32'(0));
        chk("rst_acc_last", 32'(acc_last),  32'(0));
        chk("rst_sel_buf",  32'(sel_buf),   32'(0));
        chk("rst_out_v",    32'(out_v),     32'(0));
        chk("rst_in_rdy1",  32'(in_rdy1),   32'(0));
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // Continuous stream of two vectors, both instances running together.
        do_reset();
        pulses = 0;
        for (int c = 0; c < 28; c++) begin
            in_v = (c < 24); out_rdy = 1'b1; in_v1 = 1'b1;
            #1;
            if (c < 24) begin
                chk("s1_wmem",    32'(wmem_addr), 32'(c % 12));
                chk("s1_ibuf_we", 32'(ibuf_we),   32'((c % 12) < 4));
                chk("s1_in_rdy",  32'(in_rdy),    32'((c % 12) < 4));
                if ((c % 12) < 4) chk("s1_waddr", 32'(ibuf_waddr), 32'(c % 4));
                else              chk("s1_raddr", 32'(ibuf_raddr), 32'(c % 4));
            end
            if (c >= 1 && c <= 24) begin
                chk("s1_sel_buf",  32'(sel_buf),  32'(((c - 1) % 12) >= 4));
                chk("s1_mac_en",   32'(mac_en),   32'(1));
                chk("s1_acc_clr",  32'(acc_clr),  32'(((c - 1) % 4) == 0));
                chk("s1_acc_last", 32'(acc_last), 32'(((c - 1) % 4) == 3));
            end else begin
                chk("s1_mac_idle", 32'(mac_en), 32'(0));
            end
            chk("s1_out_v", 32'(out_v), 32'(c >= 3 && (c - 3) < 24 && ((c - 3) % 4) == 3));
            if (out_v) pulses++;
            chk("s5_in_rdy1", 32'(in_rdy1), 32'(1));
            if (c >= 1) begin
                chk("s5_mac_en1",   32'(mac_en1),   32'(1));
                chk("s5_acc_clr1",  32'(acc_clr1),  32'(1));
                chk("s5_acc_last1", 32'(acc_last1), 32'(1));
            end
            chk("s5_out_v1", 32'(out_v1), 32'(c >= 3));
            step();
        end
        chk("s6_pulses", 32'(pulses), 32'(6));

        // in_v toggling during LOAD: bubbles must not advance or strobe.
        do_reset();
        b = 0; pb = 0; pulses = 0; prev_issue = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_v = ((c % 2) == 0) && (b < 12); out_rdy = 1'b1;
            #1;
            lo = (b < 4);
            if (b < 12) chk("s2_wmem", 32'(wmem_addr), 32'(b));
            if (lo) chk("s2_in_rdy", 32'(in_rdy), 32'(1));
            chk("s2_mac_en", 32'(mac_en), 32'(prev_issue));
            if (prev_issue) begin
                chk("s2_acc_clr",  32'(acc_clr),  32'((pb % 4) == 0));
                chk("s2_acc_last", 32'(acc_last), 32'((pb % 4) == 3));
            end
            if (out_v) pulses++;
            issue_m = (b < 12) && (lo ? in_v : 1'b1);
            prev_issue = issue_m;
            if (issue_m) begin
                pb = b;
                b++;
            end
            step();
        end
        chk("s2_pulses", 32'(pulses), 32'(3));

        // Backpressure: 5-cycle stall in REPLAY, then a 1-cycle stall in LOAD.
        do_reset();
        pulses = 0;
        for (int c = 0; c < 23; c++) begin
            in_v = 1'b1;
            out_rdy = !((c >= 6 && c <= 10) || c == 19);
            #1;
            if (c >= 6 && c <= 10) begin
                chk("s3_hold_out_v", 32'(out_v),     32'(1));
                chk("s3_hold_wmem",  32'(wmem_addr), 32'(6));
                chk("s3_hold_rdy",   32'(in_rdy),    32'(0));
            end
            if (c == 11) chk("s3_rel_wmem", 32'(wmem_addr), 32'(6));
            if (c == 12) begin
                chk("s3_after_out_v", 32'(out_v),     32'(0));
                chk("s3_after_wmem",  32'(wmem_addr), 32'(7));
            end
            if (c == 15) chk("s3_next_out_v", 32'(out_v), 32'(1));
            if (c == 19) begin
                chk("s3_load_rdy",  32'(in_rdy),    32'(0));
                chk("s3_load_we",   32'(ibuf_we),   32'(0));
                chk("s3_load_wmem", 32'(wmem_addr), 32'(2));
                chk("s3_load_outv", 32'(out_v),     32'(1));
            end
            if (c == 20) begin
                chk("s3_resume_rdy",  32'(in_rdy),    32'(1));
                chk("s3_resume_wmem", 32'(wmem_addr), 32'(2));
                chk("s3_resume_outv", 32'(out_v),     32'(1));
            end
            if (c >= 6 && c <= 12 && out_v && out_rdy) pulses++;
            step();
        end
        chk("s3_one_xfer", 32'(pulses), 32'(1));

        // Reset at beat 6 of a vector: no stale output afterwards.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            in_v = 1'b1; out_rdy = 1'b1;
            #1;
            if (c == 6) chk("s4_pre_out_v", 32'(out_v), 32'(1));
            if (c < 6) step();
        end
        do_reset();
        in_v = 1'b1;
        #1;
        chk("s4_wmem",  32'(wmem_addr),  32'(0));
        chk("s4_waddr", 32'(ibuf_waddr), 32'(0));
        chk("s4_we",    32'(ibuf_we),    32'(1));
        step();
        in_v = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("s4_no_stale", 32'(out_v), 32'(0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mvau_fold_ctrl.md
# mvau_fold_ctrl

Sequencing controller for the matrix-vector activation unit datapath. It accepts each input activation vector as SF beats over a valid/ready stream and writes the beats into the input buffer. It then replays the buffered vector NF times, once per neuron fold. For each beat it drives the weight-memory address, the MAC enable/clear/last strobes and the output-valid stream, and it applies downstream backpressure to the whole pipeline. It sits between the input stream, the input buffer, the per-PE weight memories and the streaming MAC unit.

## Interface
- SF, 4, synapse fold = MatrixW/SIMD; beats per input vector (≥1)
- NF, 3, neuron fold = MatrixH/PE; output words per input vector (≥1)
- DP_LAT, 2, cycles from a mac_en beat to its accumulated result at the datapath output (≥1)
- WMEM_ADDR_BW, $clog2(SF*NF), weight memory address width (minimum 1)
- IBUF_ADDR_BW, $clog2(SF), input buffer address width (minimum 1)
- clk  in  1  main clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_v  in  1  input activation beat valid
- in_rdy  out  1  controller accepts the beat
- ibuf_we  out  1  input buffer write enable (combinational)
- ibuf_waddr  out  IBUF_ADDR_BW  input buffer write address
- ibuf_raddr  out  IBUF_ADDR_BW  input buffer read address
- wmem_addr  out  WMEM_ADDR_BW  weight memory address (synchronous read, 1 cycle)
- sel_buf  out  1  registered; 0 = datapath takes the delayed input stream, 1 = buffer read data
- mac_en  out  1  registered; MAC consumes this beat
- acc_clr  out  1  registered; first beat of a fold, accumulator loads instead of adding
- acc_last  out  1  registered; last beat of a fold
- out_v  out  1  output word valid
- out_rdy  in  1  downstream accepts the output word

## Operation
- Counters: sf_cnt 0..SF-1 and nf_cnt 0..NF-1. wmem_addr is a separate counter equal to nf_cnt*SF+sf_cnt; it increments per issued beat and wraps from SF*NF-1 to 0.
- stall = out_v & ~out_rdy. While stall is high, all counters, the state and the pipeline hold.
- FSM states:
  - LOAD (reset state, nf_cnt=0). in_rdy = ~stall. A beat issues on in_v & in_rdy: ibuf_we=1, ibuf_waddr=sf_cnt, sel_buf=0.
  - REPLAY (nf_cnt>0). in_rdy=0. A beat issues every cycle that stall is low: ibuf_raddr=sf_cnt, sel_buf=1.
- On an issued beat:
  - sf_cnt increments.
  - At sf_cnt=SF-1, sf_cnt wraps to 0 and nf_cnt increments.
  - At nf_cnt=NF-1 with sf_cnt=SF-1, nf_cnt wraps to 0 and the next state is LOAD. Otherwise the next state is REPLAY.
- Transition rules:
  - NF=1: the FSM never leaves LOAD.
  - SF=1: acc_clr and acc_last are both 1 on every beat.
- Issue strobes are registered one cycle after the issue cycle, aligned with the weight read data:
  - mac_en=1 only for issued beats; bubbles give mac_en=0.
  - acc_clr = (sf_cnt==0) and acc_last = (sf_cnt==SF-1), both sampled at issue.
- Output pipeline: a DP_LAT-stage shift register carries (mac_en & acc_last), advancing when stall is low. Its last stage is out_v. An output word transfers on out_v & out_rdy.

## Timing
- Reset values, applied asynchronously:
  - state=LOAD; sf_cnt, nf_cnt, wmem_addr = 0
  - mac_en, acc_clr, acc_last, sel_buf, out_v, shift register = 0
  - in_rdy=1 one cycle after rst_n deasserts; in_rdy=0 while rst_n is low
- Latency: the last input beat accepted at cycle t gives out_v at cycle t+1+DP_LAT with no stall.
- With no stalls, each vector takes SF*NF issue cycles, and the next vector's first beat is accepted back-to-back.
- Stall: out_v and the pending word hold until out_rdy. in_rdy drops in the same cycle, combinationally from out_v/out_rdy. No beat or output is lost or duplicated.
- Simultaneous events:
  - out_v & out_rdy while a new beat issues: both proceed in the same cycle.
  - in_v arriving during REPLAY is ignored (in_rdy=0); the source must hold it.
- Reset mid-operation discards the partial vector and all in-flight pipeline bits. No out_v is asserted afterwards for pre-reset beats.

## Structure
- The shared package mvau_defn holds SF, NF, DP_LAT defaults and the typedef fold_state_e {LOAD, REPLAY}.
- One sub-module, mvau_fold_cnt: a parameterised mod-N counter with en, a wrap flag and asynchronous active-low reset, instantiated for sf_cnt, nf_cnt and wmem_addr.
- The DP_LAT valid shift register stays inline.

## Test plan
All scenarios use SF=4, NF=3, DP_LAT=2.
- Reset, then in_v=1 continuously with out_rdy=1:
  - wmem_addr sequence 0..11 then 0, ibuf_we high only on addresses 0..3, sel_buf=1 on beats 4..11
  - first out_v exactly 3 cycles after the 4th input beat; 3 out_v pulses per vector
- in_v toggling 1/0 during LOAD: bubbles give mac_en=0, addresses do not advance on bubbles, and results match scenario 1.
- out_rdy=0 for 5 cycles while out_v=1: out_v, wmem_addr and nf_cnt hold, in_rdy=0; after out_rdy rises, exactly one transfer occurs and the sequence resumes.
- Reset asserted at beat 6 of a vector: every output returns to its reset value immediately; the next accepted beat uses wmem_addr=0, ibuf_waddr=0; no stale out_v appears.
- NF=1, SF=1 build: in_rdy stays 1 and every accepted beat gives mac_en=acc_clr=acc_last=1 and an out_v DP_LAT+1 cycles later.
- Two back-to-back vectors with out_rdy=1: 6 out_v pulses, wmem_addr wraps 11→0 at the vector boundary with no idle cycle.
